keypad_conditioner: RTL and testbench

- Front-end stage between the raw front-panel switches and the microwave controller top level.
- Synchronises and debounces the ten digit keys and the start/stop/clear buttons.
- Produces the clean one-hot `keypad[9:0]` vector plus active-low `startn`/`stopn`/`clearn` that the controller's timer-input and magnetron blocks consume.
- Rejects chatter and multi-digit presses so at most one digit is ever presented downstream.

---
 rtl/keypad_conditioner_pkg.sv | 43 ++++
 rtl/button_debounce.sv | 55 +++++
 rtl/keypad_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_conditioner_pkg.sv
// Shared types and helpers for the front-panel keypad conditioner:
// digit FSM encodings, the default debounce depth and one-hot utilities.
package keypad_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 3;
    localparam int NUM_DIGITS          = 10;
    localparam int IDX_W               = 4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REJECT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } digit_state_e;

    // True when exactly one digit line is active.
    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // Index of the active line; only meaningful when the vector is one-hot.
    function automatic logic [IDX_W-1:0] one_hot_index(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Rebuild the one-hot vector from a stored index, so the presented
    // keypad value can never be multi-hot.
    function automatic logic [NUM_DIGITS-1:0] index_to_one_hot(input logic [IDX_W-1:0] idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button conditioner: 2-flop synchroniser followed by a counter
// debouncer. The output flips only after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it; any agreeing sample restarts
// the count. ACTIVE_LOW inverts the presented level.
module button_debounce
    import keypad_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 3,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             s_level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            s_level <= 1'b0;
        end else begin
            sync_q1 <= raw;
            s_level <= sync_q1;
        end
    end

    // Count disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            level_q <= 1'b0;
            cnt     <= '0;
        end else if (s_level != level_q) begin
            if (cnt == CNT_LAST) begin
                level_q <= s_level;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = ACTIVE_LOW ? ~level_q : level_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Front-panel conditioner for the microwave controller. Synchronises and
// debounces the ten digit keys through a single FSM that presents at most
// one digit, and runs start/stop/clear through independent debouncers.
// DEBOUNCE_CYCLES is expected to be at least 2 and to fit in CNT_W bits.
module keypad_conditioner
    import keypad_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_DIGITS-1:0] raw_digits,
    input  logic                  raw_start,
    input  logic                  raw_stop,
    input  logic                  raw_clear,
    output logic [NUM_DIGITS-1:0] keypad,
    output logic                  startn,
    output logic                  stopn,
    output logic                  clearn,
    output logic                  multi_key
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               NUM_CMD  = 3;

    logic [NUM_DIGITS-1:0] d_sync1;
    logic [NUM_DIGITS-1:0] s_digits;

    digit_state_e          state;
    digit_state_e          state_nxt;
    logic [IDX_W-1:0]      latch_idx;
    logic [IDX_W-1:0]      latch_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CNT_W-1:0]      cnt_inc;

    logic                  s_one_hot;
    logic                  s_zero;
    logic                  s_match;
    logic [NUM_DIGITS-1:0] keypad_d;
    logic                  multi_d;

    // ------------------------------------------------------------------
    // Digit path
    // ------------------------------------------------------------------

    // Two-flop synchroniser across all digit lines.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d_sync1  <= '0;
            s_digits <= '0;
        end else begin
            d_sync1  <= raw_digits;
            s_digits <= d_sync1;
        end
    end

    assign s_one_hot = is_one_hot(s_digits);
    assign s_zero    = (s_digits == '0);
    assign s_match   = (s_digits == index_to_one_hot(latch_idx));
    // Saturating increment so the counter can never wrap.
    assign cnt_inc   = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

    // FSM state, latched digit index and debounce counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            latch_idx <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            latch_idx <= latch_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Next-state logic. The sample that enters PRESS_WAIT or RELEASE_WAIT
    // already counts as the first stable sample, so the counter reaching
    // DEBOUNCE_CYCLES-1 there marks DEBOUNCE_CYCLES samples in a row.
    // REJECT enters with no zero sample seen yet, so it counts one further.
    always_comb begin
        state_nxt = state;
        latch_nxt = latch_idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (s_one_hot) begin
                    latch_nxt = one_hot_index(s_digits);
                    state_nxt = PRESS_WAIT;
                end else if (!s_zero) begin
                    state_nxt = REJECT;
                end
            end
            PRESS_WAIT: begin
                if (s_match) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) state_nxt = HELD;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!s_match) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s_zero) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else if (s_match) begin
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = REJECT;
                end
            end
            REJECT: begin
                if (s_zero) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs change on the
    // transition edge itself.
    always_comb begin
        keypad_d = '0;
        multi_d  = 1'b0;
        case (state_nxt)
            HELD, RELEASE_WAIT: keypad_d = index_to_one_hot(latch_nxt);
            REJECT:             multi_d  = 1'b1;
            default: begin
                keypad_d = '0;
                multi_d  = 1'b0;
            end
        endcase
    end

    // Registered digit outputs; cleared immediately by reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            keypad    <= '0;
            multi_key <= 1'b0;
        end else begin
            keypad    <= keypad_d;
            multi_key <= multi_d;
        end
    end

    // At most one digit is ever presented downstream.
    a_keypad_onehot0 : assert property (@(posedge clock) disable iff (!resetn) $onehot0(keypad));

    // ------------------------------------------------------------------
    // Command buttons: independent, no priority between them.
    // ------------------------------------------------------------------

    logic [NUM_CMD-1:0] cmd_raw;
    logic [NUM_CMD-1:0] cmd_n;

    assign cmd_raw = {raw_clear, raw_stop, raw_start};

    for (genvar i = 0; i < NUM_CMD; i++) begin : g_cmd
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (1'b1)
        ) u_btn (
            .clock  (clock),
            .resetn (resetn),
            .raw    (cmd_raw[i]),
            .level  (cmd_n[i])
        );
    end

    assign startn = cmd_n[0];
    assign stopn  = cmd_n[1];
    assign clearn = cmd_n[2];

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner. Stimulus pushes each expected
// output change (cycle stamp + full output vector) into a queue; the
// monitor compares every observed output change against the queue head.
module tb_keypad_conditioner;
    import keypad_conditioner_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] raw_digits;
    logic       raw_start, raw_stop, raw_clear;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, multi_key;

    keypad_conditioner u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .raw_digits (raw_digits),
        .raw_start  (raw_start),
        .raw_stop   (raw_stop),
        .raw_clear  (raw_clear),
        .keypad     (keypad),
        .startn     (startn),
        .stopn      (stopn),
        .clearn     (clearn),
        .multi_key  (multi_key)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [13:0] val;
    } ev_t;

    localparam logic [13:0] RST_VAL = {10'h000, 1'b0, 1'b1, 1'b1, 1'b1};

    ev_t         exp_q[$];
    ev_t         mon_e;
    int          n_pass   = 0;
    int          n_checks = 0;
    logic [13:0] prev     = RST_VAL;
    wire  [13:0] snap     = {keypad, multi_key, startn, stopn, clearn};

    function automatic logic [13:0] pack(input logic [9:0] kp, input logic mk,
                                         input logic sn, input logic tn, input logic cn);
        return {kp, mk, sn, tn, cn};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic expect_ev(input int dly, input logic [13:0] v);
        ev_t e;
        e.cyc = cyc + dly;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h at cycle %0d", name, got, want, cyc);
    endtask

    // Monitor: every output change must match the next expected event.
    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            $display("FAIL overdue: required %h at cycle %0d, outputs still %h at cycle %0d",
                     mon_e.val, mon_e.cyc, snap, cyc);
        end
        if (snap !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected: outputs %h at cycle %0d, required %h", snap, cyc, prev);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.val === snap && mon_e.cyc == cyc) n_pass++;
                else $display("FAIL event: got %h at cycle %0d, required %h at cycle %0d",
                              snap, cyc, mon_e.val, mon_e.cyc);
            end
            prev = snap;
        end
    end

    initial begin
        resetn     = 1'b0;
        raw_digits = 10'h010;
        raw_start  = 1'b0;
        raw_stop   = 1'b0;
        raw_clear  = 1'b0;

        // Reset held with digit 4 pressed: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_hold", snap, RST_VAL);
        end
        step(1);
        resetn = 1'b1;
        expect_ev(5, pack(10'h010, 1'b0, 1'b1, 1'b1, 1'b1));
        step(8);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(8);

        // Clean press of digit 7.
        raw_digits = 10'h080;
        expect_ev(5, pack(10'h080, 1'b0, 1'b1, 1'b1, 1'b1));
        step(10);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(8);

        // Digit 3 bounces 1,0,1,0 then settles high.
        for (int i = 0; i < 4; i++) begin
            raw_digits = (i % 2 == 0) ? 10'h008 : 10'h000;
            step(1);
        end
        raw_digits = 10'h008;
        expect_ev(5, pack(10'h008, 1'b0, 1'b1, 1'b1, 1'b1));
        step(9);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(8);

        // Digits 2 and 5 together are rejected, then digit 5 alone is accepted.
        raw_digits = 10'h024;
        expect_ev(3, pack(10'h000, 1'b1, 1'b1, 1'b1, 1'b1));
        step(6);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(6);
        raw_digits = 10'h020;
        expect_ev(5, pack(10'h020, 1'b0, 1'b1, 1'b1, 1'b1));
        step(8);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(8);

        // Digit 1: short release bounces keep it held; sliding to digit 6 rejects.
        raw_digits = 10'h002;
        expect_ev(5, pack(10'h002, 1'b0, 1'b1, 1'b1, 1'b1));
        step(8);
        raw_digits = 10'h000;
        step(1);
        raw_digits = 10'h002;
        step(6);
        raw_digits = 10'h000;
        step(2);
        raw_digits = 10'h002;
        step(6);
        raw_digits = 10'h040;
        expect_ev(4, pack(10'h000, 1'b1, 1'b1, 1'b1, 1'b1));
        step(6);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(8);

        // Start and clear together; stop untouched.
        raw_start = 1'b1;
        raw_clear = 1'b1;
        expect_ev(5, pack(10'h000, 1'b0, 1'b0, 1'b1, 1'b0));
        step(8);
        raw_start = 1'b0;
        raw_clear = 1'b0;
        expect_ev(5, RST_VAL);
        step(8);

        // Two-cycle stop glitch is ignored; a real stop press is taken.
        raw_stop = 1'b1;
        step(2);
        raw_stop = 1'b0;
        step(8);
        raw_stop = 1'b1;
        expect_ev(5, pack(10'h000, 1'b0, 1'b1, 1'b0, 1'b1));
        step(6);
        raw_stop = 1'b0;
        expect_ev(5, RST_VAL);
        step(8);

        // Asynchronous reset while digit 9 is held.
        raw_digits = 10'h200;
        expect_ev(5, pack(10'h200, 1'b0, 1'b1, 1'b1, 1'b1));
        step(7);
        expect_ev(0, RST_VAL);
        resetn = 1'b0;
        #1;
        chk("async_reset", snap, RST_VAL);
        step(2);
        resetn = 1'b1;
        #1;
        n_checks++;
        if (u_dut.state === IDLE) n_pass++;
        else $display("FAIL state_after_reset: got %0d required %0d", u_dut.state, IDLE);
        expect_ev(5, pack(10'h200, 1'b0, 1'b1, 1'b1, 1'b1));
        step(8);
        raw_digits = 10'h000;
        expect_ev(5, RST_VAL);
        step(10);

        // Every expected event must have been observed.
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_events: %0d left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
